if_id_buf: RTL and testbench

- Decoupling buffer between the instruction fetch stage and the decode stage.
- Accepts {pc, inst} pairs from fetch through a valid/ready handshake and stores them in a small circular FIFO.
- Presents the oldest pair to decode through a valid/ready handshake.
- Supports a pipeline hold (stall) and a flush on jump/branch redirect. Outputs a canonical NOP when no instruction is available.

---
 rtl/if_id_buf.sv | 93 +++++++++
 tb/tb_if_id_buf.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/if_id_buf.sv
// Fetch-to-decode decoupling FIFO with valid/ready on both sides.
// Hold freezes the decode side; flush discards every buffered pair.
module if_id_buf #(
  parameter int unsigned         DATA_W   = 32,
  parameter int unsigned         DEPTH    = 2,
  parameter logic [DATA_W-1:0]   NOP_INST = 'h13
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       ifu_valid_i,
  input  logic [DATA_W-1:0]          ifu_pc_i,
  input  logic [DATA_W-1:0]          ifu_inst_i,
  output logic                       ifu_ready_o,
  output logic                       id_valid_o,
  output logic [DATA_W-1:0]          id_pc_o,
  output logic [DATA_W-1:0]          id_inst_o,
  input  logic                       id_ready_i,
  input  logic                       hold_i,
  input  logic                       flush_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef struct packed {
    logic [DATA_W-1:0] pc;
    logic [DATA_W-1:0] inst;
  } entry_t;

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic push;
  logic pop;
  logic empty;

  assign empty = (count_q == '0);

  assign ifu_ready_o = (count_q != FULL) && !flush_i;
  assign id_valid_o  = !empty && !hold_i && !flush_i;

  // Empty buffer shows a canonical NOP, never stale storage
  assign id_pc_o   = empty ? '0       : mem_q[rd_ptr_q].pc;
  assign id_inst_o = empty ? NOP_INST : mem_q[rd_ptr_q].inst;

  assign count_o = count_q;

  assign push = ifu_valid_i && ifu_ready_o;
  assign pop  = id_valid_o && id_ready_i;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    unique case (1'b1)
      flush_i: begin
        wr_ptr_d = '0;
        rd_ptr_d = '0;
        count_d  = '0;
      end
      default: begin
        if (push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        unique case ({push, pop})
          2'b10:   count_d = count_q + CW'(1);
          2'b01:   count_d = count_q - CW'(1);
          default: count_d = count_q;
        endcase
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= '{pc: ifu_pc_i, inst: ifu_inst_i};
  end

endmodule

// File: tb/tb_if_id_buf.sv
// Randomized bench for if_id_buf against a queue-based FIFO model.
// Directed test-plan scenarios run first, then random traffic.
module tb_if_id_buf;

  localparam int DW    = 32;
  localparam int DEPTH = 2;
  localparam logic [31:0] NOP = 32'h00000013;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ifu_valid_i;
  logic [DW-1:0] ifu_pc_i;
  logic [DW-1:0] ifu_inst_i;
  logic          ifu_ready_o;
  logic          id_valid_o;
  logic [DW-1:0] id_pc_o;
  logic [DW-1:0] id_inst_o;
  logic          id_ready_i;
  logic          hold_i;
  logic          flush_i;
  logic [1:0]    count_o;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } ent_t;

  ent_t q[$];

  if_id_buf #(.DATA_W(DW), .DEPTH(DEPTH), .NOP_INST(NOP)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ifu_valid_i (ifu_valid_i),
    .ifu_pc_i    (ifu_pc_i),
    .ifu_inst_i  (ifu_inst_i),
    .ifu_ready_o (ifu_ready_o),
    .id_valid_o  (id_valid_o),
    .id_pc_o     (id_pc_o),
    .id_inst_o   (id_inst_o),
    .id_ready_i  (id_ready_i),
    .hold_i      (hold_i),
    .flush_i     (flush_i),
    .count_o     (count_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic [31:0] pc,
                      input logic [31:0] inst, input logic rdy,
                      input logic hold, input logic flush);
    logic        e_rdy, e_val;
    logic [31:0] e_pc, e_inst;
    bit          push, pop;
    @(negedge clk);
    ifu_valid_i = v;
    ifu_pc_i    = pc;
    ifu_inst_i  = inst;
    id_ready_i  = rdy;
    hold_i      = hold;
    flush_i     = flush;
    #1;
    e_rdy  = (q.size() != DEPTH) && !flush;
    e_val  = (q.size() != 0) && !hold && !flush;
    e_pc   = (q.size() != 0) ? q[0].pc : 32'h0;
    e_inst = (q.size() != 0) ? q[0].inst : NOP;
    chk("ready", {31'b0, ifu_ready_o}, {31'b0, e_rdy});
    chk("valid", {31'b0, id_valid_o}, {31'b0, e_val});
    chk("pc", id_pc_o, e_pc);
    chk("inst", id_inst_o, e_inst);
    chk("count", {30'b0, count_o}, q.size());
    push = v && e_rdy;
    pop  = e_val && rdy;
    @(posedge clk);
    if (flush) q.delete();
    else begin
      if (pop)  void'(q.pop_front());
      if (push) q.push_back({pc, inst});
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_valid"}, {31'b0, id_valid_o}, 32'd0);
    chk({tag, "_pc"}, id_pc_o, 32'h0);
    chk({tag, "_inst"}, id_inst_o, NOP);
    chk({tag, "_count"}, {30'b0, count_o}, 32'd0);
    chk({tag, "_ready"}, {31'b0, ifu_ready_o}, 32'd1);
  endtask

  initial begin
    logic [31:0] rpc;
    rst_n = 1'b0;
    ifu_valid_i = 1'b0;
    ifu_pc_i = '0;
    ifu_inst_i = '0;
    id_ready_i = 1'b0;
    hold_i = 1'b0;
    flush_i = 1'b0;
    #2;
    chk_idle_outputs("rst");
    #10 rst_n = 1'b1;

    // single push then pop
    step(1, 32'h0, 32'h00500093, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);

    // fill to full with decode stalled, then drain in order
    step(1, 32'h4, 32'h1004, 0, 0, 0);
    step(1, 32'h8, 32'h1008, 0, 0, 0);
    step(1, 32'hC, 32'h100C, 0, 0, 0);
    chk("full_count", {30'b0, count_o}, 32'd2);
    step(1, 32'hC, 32'h100C, 1, 0, 0);
    step(1, 32'hC, 32'h100C, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);

    // streaming push+pop every cycle
    for (int i = 0; i < 6; i++)
      step(1, 32'h100 + 4 * i, 32'h2000 + i, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);

    // hold with two entries
    step(1, 32'h10, 32'h3010, 0, 0, 0);
    step(1, 32'h14, 32'h3014, 0, 0, 0);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 1, 1, 0);
    chk("hold_pc", id_pc_o, 32'h10);
    for (int i = 0; i < 3; i++) step(0, 32'h0, 32'h0, 1, 0, 0);

    // flush while full with a pending push and pop
    step(1, 32'h20, 32'h4020, 0, 0, 0);
    step(1, 32'h24, 32'h4024, 0, 0, 0);
    step(1, 32'h18, 32'h4018, 1, 0, 1);
    step(1, 32'h1C, 32'h401C, 1, 0, 0);
    step(0, 32'h0, 32'h0, 1, 0, 0);

    // asynchronous reset between edges while full
    step(1, 32'h30, 32'h5030, 0, 0, 0);
    step(1, 32'h34, 32'h5034, 0, 0, 0);
    @(negedge clk);
    ifu_valid_i = 1'b0;
    id_ready_i = 1'b0;
    chk("pre_rst_count", {30'b0, count_o}, 32'd2);
    #1 rst_n = 1'b0;
    #1;
    chk_idle_outputs("arst");
    q.delete();
    #1 rst_n = 1'b1;

    // random traffic
    rpc = 32'h8000;
    for (int i = 0; i < 2000; i++) begin
      logic v, r, h, f;
      v = ($urandom_range(0, 9) < 7);
      r = ($urandom_range(0, 9) < 6);
      h = ($urandom_range(0, 9) < 2);
      f = ($urandom_range(0, 19) == 0);
      step(v, rpc, $urandom, r, h, f);
      rpc = rpc + 4;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
